// File: rtl/prf_write_arbiter.sv
// PRF write arbiter: per-requestor holding registers, per-bank round-robin grant,
// registered bank write ports and completion broadcast. Optional: PRF_WR_ARB_STATS_EN.
module prf_write_arbiter #(
  parameter int XLEN           = 32,
  parameter int PR_COUNT       = 64,
  parameter int PRF_BANK_COUNT = 4,
  parameter int PRF_WR_COUNT   = 7,
  localparam int LOG_PR_COUNT       = $clog2(PR_COUNT),
  localparam int LOG_PRF_BANK_COUNT = $clog2(PRF_BANK_COUNT),
  localparam int ROW_W              = LOG_PR_COUNT - LOG_PRF_BANK_COUNT
) (
  input  logic                                          CLK,
  input  logic                                          nRST,
  input  logic [PRF_WR_COUNT-1:0]                       wr_valid_by_wr,
  input  logic [PRF_WR_COUNT-1:0][LOG_PR_COUNT-1:0]     wr_PR_by_wr,
  input  logic [PRF_WR_COUNT-1:0][XLEN-1:0]             wr_data_by_wr,
  output logic [PRF_WR_COUNT-1:0]                       wr_ready_by_wr,
  output logic [PRF_BANK_COUNT-1:0]                     bank_we_by_bank,
  output logic [PRF_BANK_COUNT-1:0][ROW_W-1:0]          bank_row_by_bank,
  output logic [PRF_BANK_COUNT-1:0][XLEN-1:0]           bank_wdata_by_bank,
  output logic [PRF_BANK_COUNT-1:0]                     complete_valid_by_bank,
  output logic [PRF_BANK_COUNT-1:0][LOG_PR_COUNT-1:0]   complete_PR_by_bank
`ifdef PRF_WR_ARB_STATS_EN
  ,
  output logic [PRF_BANK_COUNT-1:0][15:0]               conflict_count_by_bank
`endif
);

  localparam int WR_IDX_W = $clog2(PRF_WR_COUNT);
  typedef logic [WR_IDX_W-1:0] wr_idx_t;

  logic [PRF_WR_COUNT-1:0]   hold_valid;
  logic [LOG_PR_COUNT-1:0]   hold_pr   [PRF_WR_COUNT];
  logic [XLEN-1:0]           hold_data [PRF_WR_COUNT];
  wr_idx_t                   rr_ptr    [PRF_BANK_COUNT];

  logic [PRF_WR_COUNT-1:0]   grant_by_wr;
  logic [PRF_BANK_COUNT-1:0] grant_by_bank;
  wr_idx_t                   winner_by_bank    [PRF_BANK_COUNT];
  logic [LOG_PR_COUNT-1:0]   winner_pr_by_bank [PRF_BANK_COUNT];
  logic [XLEN-1:0]           winner_data_by_bank [PRF_BANK_COUNT];

  function automatic logic [LOG_PRF_BANK_COUNT-1:0] bank_of(input logic [LOG_PR_COUNT-1:0] pr);
    return pr[LOG_PRF_BANK_COUNT-1:0];
  endfunction

  // Per bank, scan requestors starting at rr_ptr and take the first valid holder.
  always_comb begin : arbitrate
    logic [WR_IDX_W:0] cand_sum;
    wr_idx_t           cand;
    // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
    grant_by_wr   = '0;
    grant_by_bank = '0;
    cand_sum      = '0;
    cand          = '0;
    for (int b = 0; b < PRF_BANK_COUNT; b++) begin
      winner_by_bank[b] = '0;
      for (int i = 0; i < PRF_WR_COUNT; i++) begin
        cand_sum = {1'b0, rr_ptr[b]} + (WR_IDX_W+1)'(i);
        if (cand_sum >= (WR_IDX_W+1)'(PRF_WR_COUNT))
          cand_sum = cand_sum - (WR_IDX_W+1)'(PRF_WR_COUNT);
        cand = cand_sum[WR_IDX_W-1:0];
        if (!grant_by_bank[b] && hold_valid[cand] &&
            bank_of(hold_pr[cand]) == LOG_PRF_BANK_COUNT'(b)) begin
          grant_by_bank[b]  = 1'b1;
          winner_by_bank[b] = cand;
          grant_by_wr[cand] = 1'b1;
        end
      end
      winner_pr_by_bank[b]   = hold_pr[winner_by_bank[b]];
      winner_data_by_bank[b] = hold_data[winner_by_bank[b]];
    end
  end

  // A granted holder frees up this cycle, so it can be reloaded on the same edge.
  assign wr_ready_by_wr = ~hold_valid | grant_by_wr;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      hold_valid <= '0;
      for (int w = 0; w < PRF_WR_COUNT; w++) begin
        hold_pr[w]   <= '0;
        hold_data[w] <= '0;
      end
    end else begin
      for (int w = 0; w < PRF_WR_COUNT; w++) begin
        if (wr_valid_by_wr[w] && wr_ready_by_wr[w]) begin
          hold_valid[w] <= 1'b1;
          hold_pr[w]    <= wr_PR_by_wr[w];
          hold_data[w]  <= wr_data_by_wr[w];
        end else if (grant_by_wr[w]) begin
          hold_valid[w] <= 1'b0;
        end
      end
    end
  end

  // Grants to PR 0 still consume the holder and advance the pointer, but write nothing.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      bank_we_by_bank        <= '0;
      bank_row_by_bank       <= '0;
      bank_wdata_by_bank     <= '0;
      complete_valid_by_bank <= '0;
      complete_PR_by_bank    <= '0;
      for (int b = 0; b < PRF_BANK_COUNT; b++) rr_ptr[b] <= '0;
    end else begin
      for (int b = 0; b < PRF_BANK_COUNT; b++) begin
        if (grant_by_bank[b] && winner_pr_by_bank[b] != '0) begin
          bank_we_by_bank[b]        <= 1'b1;
          bank_row_by_bank[b]       <= winner_pr_by_bank[b][LOG_PR_COUNT-1:LOG_PRF_BANK_COUNT];
          bank_wdata_by_bank[b]     <= winner_data_by_bank[b];
          complete_valid_by_bank[b] <= 1'b1;
          complete_PR_by_bank[b]    <= winner_pr_by_bank[b];
        end else begin
          bank_we_by_bank[b]        <= 1'b0;
          bank_row_by_bank[b]       <= '0;
          bank_wdata_by_bank[b]     <= '0;
          complete_valid_by_bank[b] <= 1'b0;
          complete_PR_by_bank[b]    <= '0;
        end
        if (grant_by_bank[b]) begin
          if (winner_by_bank[b] == WR_IDX_W'(PRF_WR_COUNT - 1)) rr_ptr[b] <= '0;
          else                                                 rr_ptr[b] <= winner_by_bank[b] + 1'b1;
        end
      end
    end
  end

`ifdef PRF_WR_ARB_STATS_EN
  localparam int CNT_W = $clog2(PRF_WR_COUNT + 1);
  logic [PRF_BANK_COUNT-1:0] conflict_by_bank;

  always_comb begin : count_eligible
    logic [CNT_W-1:0] n_elig;
    conflict_by_bank = '0;
    n_elig           = '0;
    for (int b = 0; b < PRF_BANK_COUNT; b++) begin
      n_elig = '0;
      for (int w = 0; w < PRF_WR_COUNT; w++)
        if (hold_valid[w] && bank_of(hold_pr[w]) == LOG_PRF_BANK_COUNT'(b))
          n_elig = n_elig + CNT_W'(1);
      conflict_by_bank[b] = (n_elig >= CNT_W'(2));
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      conflict_count_by_bank <= '0;
    end else begin
      for (int b = 0; b < PRF_BANK_COUNT; b++)
        if (conflict_by_bank[b] && conflict_count_by_bank[b] != 16'hFFFF)
          conflict_count_by_bank[b] <= conflict_count_by_bank[b] + 16'd1;
    end
  end
`endif

endmodule

// File: doc/prf_write_arbiter.md
Name: prf_write_arbiter

Overview:
- Write-side front end of the banked physical register file; the counterpart to the PRF read-requestor/read-port path.
- Accepts writeback requests from PRF_WR_COUNT functional-unit requestors and buffers each in a 1-entry holding register.
- Arbitrates round-robin per bank, one write per bank per cycle, and drives registered bank write ports plus a completion broadcast used for wakeup/ROB complete.

Parameters:
- XLEN, 32, data width
- PR_COUNT, 64, physical register count; LOG_PR_COUNT = $clog2(PR_COUNT)
- PRF_BANK_COUNT, 4, PRF banks; LOG_PRF_BANK_COUNT = $clog2(PRF_BANK_COUNT)
- PRF_WR_COUNT, 7, write requestor count

Ports:
- CLK  input  1  clock
- nRST  input  1  asynchronous active-low reset
- wr_valid_by_wr  input  [PRF_WR_COUNT]  write request valid
- wr_PR_by_wr  input  [PRF_WR_COUNT][LOG_PR_COUNT]  destination physical register
- wr_data_by_wr  input  [PRF_WR_COUNT][XLEN]  write data
- wr_ready_by_wr  output  [PRF_WR_COUNT]  requestor may present a new write
- bank_we_by_bank  output  [PRF_BANK_COUNT]  bank write enable
- bank_row_by_bank  output  [PRF_BANK_COUNT][LOG_PR_COUNT-LOG_PRF_BANK_COUNT]  row within bank
- bank_wdata_by_bank  output  [PRF_BANK_COUNT][XLEN]  bank write data
- complete_valid_by_bank  output  [PRF_BANK_COUNT]  completion broadcast valid
- complete_PR_by_bank  output  [PRF_BANK_COUNT][LOG_PR_COUNT]  completed physical register

Behaviour:
- Bank = PR[LOG_PRF_BANK_COUNT-1:0]; row = PR >> LOG_PRF_BANK_COUNT.
- Per requestor: holding register {valid, PR, data}.
- wr_ready = ~hold_valid | hold_granted_this_cycle (combinational).
- Accept when wr_valid & wr_ready.
  - Holding empty: load.
  - Granted this cycle: reload the same edge; the new entry is not eligible until the next cycle.
- Arbitration considers only valid holding registers. Per bank: round-robin over requestors targeting that bank, starting at rr_ptr[bank].
  - On grant, rr_ptr[bank] = winner+1 mod PRF_WR_COUNT.
  - No grant: pointer unchanged.
- Grant clears the holding valid unless reloaded. Losers hold, and ready stays 0 for them.
- Outputs are registered on the grant cycle edge; latency is accept at edge N, eligible at N, outputs asserted after edge N+1 (2-cycle minimum).
- bank_we and complete_valid assert together for one cycle per grant, with complete_PR = full PR.
- PR 0: accepted and consumed like any grant, but bank_we = 0 and complete_valid = 0 (writes to x0 mapping dropped).
- Banks are independent: up to PRF_BANK_COUNT writes per cycle, and all banks may grant the same cycle.
- Worst case all 7 requestors on one bank: each served within 7 cycles of becoming eligible (no starvation).
- Reset (asynchronous, any time including mid-arbitration):
  - All holding invalid; rr_ptr = 0; all registered outputs 0.
  - wr_ready_by_wr = all 1s during and after reset.
  - In-flight buffered writes are discarded.

Optional Feature:
- Macro PRF_WR_ARB_STATS_EN.
- Enabled: adds output conflict_count_by_bank [PRF_BANK_COUNT][16].
  - Per bank, increments by 1 each cycle with ≥2 eligible requestors for that bank.
  - Saturates at 16'hFFFF; reset 0.
- Disabled: port and counters absent; behaviour otherwise identical.

Test Plan:
- Single write: req 2 writes PR 13 (bank 1, row 3), data 32'hDEADBEEF. Two edges later, bank_we=4'b0010, row[1]=3, wdata=DEADBEEF, complete_PR[1]=13; wr_ready[2] stays 1.
- Four-bank parallel: reqs 0-3 write PR 4,5,6,7 same cycle. All four bank_we assert the same cycle with rows 1, and no backpressure.
- Same-bank conflict: reqs 0,3,6 write PR 8,12,16 simultaneously (bank 0). Grants occur in order 0,3,6 on consecutive cycles; wr_ready for 3 and 6 is 0 until each is granted; rr_ptr[0] ends at 0.
- Round-robin fairness: req 0 and req 1 stream continuous bank-2 writes for 20 cycles. Grants alternate 0,1,0,1 and each gets 10 writes ±1.
- PR 0 drop: req 4 writes PR 0. It is accepted, and no bank_we and no complete_valid follow. Then PR 0 plus PR 4 from different reqs to bank 0 produces exactly one bank 0 write (PR 4).
- Reset mid-operation: 3 holding registers full, assert nRST low asynchronously. All outputs are 0 immediately, wr_ready all 1. After release, no stale writes appear.
